// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug memory command engine.
package dbg_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;

  localparam logic [DATA_W-1:0] CMD_READ  = 8'h52;
  localparam logic [DATA_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [DATA_W-1:0] CMD_BURST = 8'h42;

  localparam logic [DATA_W-1:0] DEF_ACK_BYTE = 8'h4B;
  localparam logic [DATA_W-1:0] DEF_ERR_BYTE = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_WDATA,
    ST_COUNT,
    ST_MEM,
    ST_TX_SEND
  } ctrl_state_t;

  typedef enum logic [2:0] {
    MEM_IDLE,
    MEM_SETUP,
    MEM_CLK_HI,
    MEM_CLK_LO,
    MEM_DONE
  } mem_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic is_cmd(input logic [DATA_W-1:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE) || (b == CMD_BURST);
  endfunction

endpackage

// File: rtl/dbg_mem_cycle.sv
// One debug-port memory access: SETUP -> CLK_HI -> CLK_LO -> DONE, all
// RAM-side signals registered so they are glitch-free at the macro pins.
module dbg_mem_cycle
  import dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  mem_req_t          req,
  input  logic [DATA_W-1:0] dbg_data_out,
  output logic              dbg_mem_op,
  output logic              dbg_mem_clk,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data_in,
  output logic              dbg_RW,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  mem_state_t state, next_state;
  logic       op_d, clk_d, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      MEM_IDLE:   if (start) next_state = MEM_SETUP;
      MEM_SETUP:  next_state = MEM_CLK_HI;
      MEM_CLK_HI: next_state = MEM_CLK_LO;
      MEM_CLK_LO: next_state = MEM_DONE;
      MEM_DONE:   next_state = MEM_IDLE;
      default:    next_state = MEM_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    op_d   = 1'b0;
    clk_d  = 1'b0;
    done_d = 1'b0;
    unique case (next_state)
      MEM_SETUP:  op_d = 1'b1;
      MEM_CLK_HI: begin op_d = 1'b1; clk_d = 1'b1; end
      MEM_CLK_LO: op_d = 1'b1;
      MEM_DONE:   done_d = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_mem_op  <= 1'b0;
      dbg_mem_clk <= 1'b0;
      dbg_addr    <= '0;
      dbg_data_in <= '0;
      dbg_RW      <= 1'b1;
      done        <= 1'b0;
      rdata       <= '0;
    end else begin
      dbg_mem_op  <= op_d;
      dbg_mem_clk <= clk_d;
      done        <= done_d;
      if (state == MEM_IDLE && start) begin
        dbg_addr    <= req.addr;
        dbg_RW      <= req.rw;
        dbg_data_in <= req.wdata;
      end else if (next_state == MEM_DONE) begin
        dbg_RW <= 1'b1;
      end
      // Upper half is not backed by the RAM, so its bus is never sampled.
      if (state == MEM_CLK_LO)
        rdata <= dbg_addr[ADDR_W-1] ? 8'hFF : dbg_data_out;
    end
  end

endmodule

// File: rtl/dbg_mem_ctrl.sv
// Debug UART command parser: R/W/B commands sequenced onto the RAM debug
// port, with read data and ACK/ERR bytes returned over valid/ready.
module dbg_mem_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 1000000,
  parameter logic [DATA_W-1:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [DATA_W-1:0] ERR_BYTE       = DEF_ERR_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              dbg_mem_op,
  output logic              dbg_mem_clk,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data_in,
  input  logic [DATA_W-1:0] dbg_data_out,
  output logic              dbg_RW,
  output logic              busy,
  output logic              rx_overrun
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_t       state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              wr_q, burst_q;

  logic              start;
  mem_req_t          req;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic in_parse, tmo_hit, tx_fire, more;

  assign in_parse = (state == ST_ADDR_H) || (state == ST_ADDR_L) ||
                    (state == ST_WDATA)  || (state == ST_COUNT);
  assign tmo_hit  = in_parse && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tx_fire  = (state == ST_TX_SEND) && tx_ready;
  assign more     = burst_q && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:
        if (rx_valid) next_state = is_cmd(rx_data) ? ST_ADDR_H : ST_TX_SEND;
      ST_ADDR_H:
        if (tmo_hit)       next_state = ST_IDLE;
        else if (rx_valid) next_state = ST_ADDR_L;
      ST_ADDR_L:
        if (tmo_hit)       next_state = ST_IDLE;
        else if (rx_valid) next_state = wr_q ? ST_WDATA : (burst_q ? ST_COUNT : ST_MEM);
      ST_WDATA, ST_COUNT:
        if (tmo_hit)       next_state = ST_IDLE;
        else if (rx_valid) next_state = ST_MEM;
      ST_MEM:
        if (mem_done) next_state = ST_TX_SEND;
      ST_TX_SEND:
        if (tx_fire) next_state = more ? ST_MEM : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Memory request launch: fires in the cycle of the last command byte.
  always_comb begin
    start      = 1'b0;
    req.addr   = addr_q;
    req.rw     = !wr_q;
    req.wdata  = rx_data;
    unique case (state)
      ST_ADDR_L: begin
        req.addr = {addr_q[ADDR_W-1:8], rx_data};
        start    = rx_valid && !wr_q && !burst_q;
      end
      ST_WDATA, ST_COUNT: start = rx_valid;
      ST_TX_SEND: begin
        req.addr = addr_q + ADDR_W'(1);
        start    = tx_fire && more;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      wr_q       <= 1'b0;
      burst_q    <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tmo_q      <= (in_parse && !rx_valid && !tmo_hit) ? tmo_q + TMO_W'(1) : '0;
      busy       <= (next_state != ST_IDLE);
      tx_valid   <= (next_state == ST_TX_SEND);
      rx_overrun <= rx_valid && ((state == ST_MEM) || (state == ST_TX_SEND));

      if (state == ST_IDLE && rx_valid) begin
        wr_q    <= (rx_data == CMD_WRITE);
        burst_q <= (rx_data == CMD_BURST);
        if (!is_cmd(rx_data)) tx_data <= ERR_BYTE;
      end
      if (state == ST_ADDR_H && rx_valid) addr_q[ADDR_W-1:8] <= rx_data;
      if (state == ST_ADDR_L && rx_valid) addr_q[7:0]        <= rx_data;
      // Stored as remaining-after-first; N=0 wraps to 255 giving 256 bytes.
      if (state == ST_COUNT && rx_valid)  cnt_q <= rx_data - 8'd1;
      if (state == ST_MEM && mem_done)    tx_data <= wr_q ? ACK_BYTE : mem_rdata;
      if (tx_fire && more) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - 8'd1;
      end
    end
  end

  dbg_mem_cycle u_mem_cycle (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .req          (req),
    .dbg_data_out (dbg_data_out),
    .dbg_mem_op   (dbg_mem_op),
    .dbg_mem_clk  (dbg_mem_clk),
    .dbg_addr     (dbg_addr),
    .dbg_data_in  (dbg_data_in),
    .dbg_RW       (dbg_RW),
    .done         (mem_done),
    .rdata        (mem_rdata)
  );

endmodule
